fetch_stage: RTL and testbench

Instruction fetch stage and IF/ID pipeline register of the RV32 core. Holds the PC and issues one instruction-memory read at a time. Captures the returned word with its PC into an output register, and presents the opcode directly to the decode-stage control unit. Supports back-pressure from decode and PC redirect with flush from branch resolution.

---
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: RV32 instruction fetch stage and IF/ID pipeline register.
//
// The block holds the PC and issues one instruction-memory read at a time.
// It captures the returned word and its PC into the IF/ID register. The
// opcode field goes combinationally to the decode-stage control unit.
// It supports back-pressure from decode, and PC redirect with flush from
// branch resolution.
//
// Parameters:
//   RESET_PC        PC loaded on reset.
//
// Ports:
//   clk             clock, rising edge
//   rst             synchronous active-high reset
//   imem_req        read request pulse (memory always accepts)
//   imem_addr       word-aligned read address, valid with imem_req
//   imem_rvalid     read data valid
//   imem_rdata      instruction word
//   redirect_valid  branch taken: load redirect_pc and flush
//   redirect_pc     redirect target (bits [1:0] ignored)
//   id_ready        decode accepts the held instruction this cycle
//   id_valid        IF/ID register holds a valid instruction
//   id_instr        held instruction
//   id_pc           PC of the held instruction
//   id_opcode       id_instr[6:0], to the control unit
//
// Configuration macro:
//   FETCH_FLUSH_NOP_EN  when defined, id_instr is loaded with a NOP
//                       (addi x0,x0,0) whenever id_valid is cleared.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        free;
  logic        fire;
  logic        load;

  // The low bits of the redirect target are forced to zero.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    free = !id_valid || id_ready;
    fire = (state == FETCH) && free && !redirect_valid && !rst;
    load = (state == WAIT) && imem_rvalid && !redirect_valid;
  end

  assign imem_req  = fire;
  assign imem_addr = pc;
  assign id_opcode = id_instr[6:0];

  always_comb begin
    state_next = state;
    case (state)
      FETCH: if (fire) state_next = WAIT;
      WAIT: begin
        if (imem_rvalid)         state_next = FETCH;
        else if (redirect_valid) state_next = DROP;
      end
      DROP:    if (imem_rvalid) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      req_pc   <= '0;
      id_valid <= 1'b0;
      id_instr <= NOP;
      id_pc    <= '0;
    end else begin
      state <= state_next;

      if (redirect_valid) begin
        pc <= {redirect_pc[31:2], 2'b00};
      end else if (fire) begin
        req_pc <= pc;
        pc     <= pc + 32'd4;
      end

      // A load only happens in WAIT, where the register is always empty,
      // so it never races with a consume.
      if (load) begin
        id_valid <= 1'b1;
        id_instr <= imem_rdata;
        id_pc    <= req_pc;
      end else if (redirect_valid || (id_valid && id_ready)) begin
        id_valid <= 1'b0;
`ifdef FETCH_FLUSH_NOP_EN
        id_instr <= NOP;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] RPC  = 32'h0000_0100;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int          NCYC = 4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_opcode(id_opcode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Instruction memory contents: alternates lw / addi opcodes by address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:7] ^ 25'h0050001, (a[3] ? 7'b0000011 : 7'b0010011)};
  endfunction

  // Memory: one outstanding read with a random latency of at least 1 cycle.
  logic        mem_pending = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = '0;

  // Reference model at transaction level: an architectural PC, an
  // IF/ID slot, and at most one outstanding read tagged live or dead.
  logic [31:0] m_pc = RPC;
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_idpc = '0;
  logic        m_out = 1'b0;
  logic        m_live = 1'b0;
  logic [31:0] m_out_pc = '0;

  task automatic model_clear();
    m_valid = 1'b0;
`ifdef FETCH_FLUSH_NOP_EN
    m_instr = NOP;
`endif
  endtask

  initial begin
    logic exp_req, loaded, consumed;
    int   lat_max, p_ready, p_redir, p_rst;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      // Stimulus profile: clean streaming first, then stress.
      if (c < 40) begin
        lat_max = 1; p_ready = 100; p_redir = 0; p_rst = 0;
      end else if (c < 400) begin
        lat_max = 4; p_ready = 60; p_redir = 6; p_rst = 0;
      end else if (c < 700) begin
        lat_max = 3; p_ready = 15; p_redir = 3; p_rst = 0;
      end else begin
        lat_max = 5; p_ready = 70; p_redir = 8; p_rst = 1;
      end

      rst = (c < 3) || ($urandom_range(0, 99) < p_rst);
      redirect_valid = ($urandom_range(0, 99) < p_redir);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'h0000_0203;
        1:       redirect_pc = 32'hFFFF_FFF8 | $urandom_range(0, 7);
        default: redirect_pc = $urandom;
      endcase
      id_ready = ($urandom_range(0, 99) < p_ready);
      if (mem_pending) begin
        imem_rvalid = (mem_wait == 0);
        imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;
      end else begin
        // Occasional stray response while idle must be ignored.
        imem_rvalid = ($urandom_range(0, 99) < 3);
        imem_rdata  = $urandom;
      end
      #1;

      exp_req = !rst && !redirect_valid && !m_out && (!m_valid || id_ready);
      check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) check("imem_addr", imem_addr, m_pc);
      check("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
      check("id_pc", id_pc, m_idpc);
      check("id_instr", id_instr, m_instr);
      check("id_opcode", {25'b0, id_opcode}, {25'b0, m_instr[6:0]});

      // Memory advances on the DUT's actual request.
      if (rst) begin
        mem_pending = 1'b0;
      end else begin
        if (mem_pending) begin
          if (imem_rvalid) mem_pending = 1'b0;
          else             mem_wait--;
        end
        if (imem_req) begin
          mem_pending = 1'b1;
          mem_addr    = imem_addr;
          mem_wait    = $urandom_range(1, lat_max) - 1;
        end
      end

      // Model next state.
      if (rst) begin
        m_pc = RPC; m_valid = 1'b0; m_instr = NOP; m_idpc = '0; m_out = 1'b0;
      end else begin
        consumed = m_valid && id_ready;
        loaded   = 1'b0;
        if (m_out && imem_rvalid) begin
          if (m_live && !redirect_valid) begin
            m_valid = 1'b1; m_instr = imem_rdata; m_idpc = m_out_pc; loaded = 1'b1;
          end
          m_out = 1'b0;
        end
        if (redirect_valid) begin
          m_pc   = redirect_pc & 32'hFFFF_FFFC;
          m_live = 1'b0;
          model_clear();
        end else begin
          if (exp_req) begin
            m_out = 1'b1; m_live = 1'b1; m_out_pc = m_pc; m_pc = m_pc + 32'd4;
          end
          if (consumed && !loaded) model_clear();
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
